// File: rtl/falafel_mem_arb_if.sv
// falafel_mem_arb bus interfaces.
// Channel-side and memory-side bundles for the memory arbiter.

interface falafel_ch_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64
);
    logic [NUM_CH-1:0]             ch_req_val_i;
    logic [NUM_CH-1:0]             ch_req_rdy_o;
    logic [NUM_CH-1:0]             ch_req_is_write_i;
    logic [NUM_CH-1:0]             ch_req_is_cas_i;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_req_addr_i;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_req_data_i;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_req_cas_exp_i;
    logic [NUM_CH-1:0]             ch_rsp_val_o;
    logic [NUM_CH-1:0]             ch_rsp_rdy_i;
    logic [DATA_W-1:0]             ch_rsp_data_o;

    // Requesting cores / LSUs.
    modport master (
        output ch_req_val_i, ch_req_is_write_i, ch_req_is_cas_i,
        output ch_req_addr_i, ch_req_data_i, ch_req_cas_exp_i,
        input  ch_req_rdy_o,
        input  ch_rsp_val_o, ch_rsp_data_o,
        output ch_rsp_rdy_i
    );

    // Arbiter side.
    modport slave (
        input  ch_req_val_i, ch_req_is_write_i, ch_req_is_cas_i,
        input  ch_req_addr_i, ch_req_data_i, ch_req_cas_exp_i,
        output ch_req_rdy_o,
        output ch_rsp_val_o, ch_rsp_data_o,
        input  ch_rsp_rdy_i
    );
endinterface

interface falafel_mem_if #(
    parameter int DATA_W = 64
);
    logic              mem_req_val_o;
    logic              mem_req_rdy_i;
    logic              mem_req_is_write_o;
    logic              mem_req_is_cas_o;
    logic [DATA_W-1:0] mem_req_addr_o;
    logic [DATA_W-1:0] mem_req_data_o;
    logic [DATA_W-1:0] mem_req_cas_exp_o;
    logic              mem_rsp_val_i;
    logic              mem_rsp_rdy_o;
    logic [DATA_W-1:0] mem_rsp_data_i;

    // Arbiter side.
    modport master (
        output mem_req_val_o, mem_req_is_write_o, mem_req_is_cas_o,
        output mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o,
        input  mem_req_rdy_i,
        input  mem_rsp_val_i, mem_rsp_data_i,
        output mem_rsp_rdy_o
    );

    // Memory side.
    modport slave (
        input  mem_req_val_o, mem_req_is_write_o, mem_req_is_cas_o,
        input  mem_req_addr_o, mem_req_data_o, mem_req_cas_exp_o,
        output mem_req_rdy_i,
        output mem_rsp_val_i, mem_rsp_data_i,
        input  mem_rsp_rdy_o
    );
endinterface

// File: rtl/falafel_mem_arb.sv
// falafel_mem_arb: round-robin multi-channel memory front-end.
// In-order responses are steered back via an outstanding-tag FIFO.

module falafel_mem_arb #(
    parameter int  NUM_CH          = 2,
    parameter int  DATA_W          = 64,
    parameter int  MAX_OUTSTANDING = 4,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W           = $clog2(MAX_OUTSTANDING),
    localparam int CNT_W           = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    falafel_ch_if.slave      ch,
    falafel_mem_if.master    mem,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_unexp_rsp_o
);

    logic [CH_W-1:0]  rr_q;
    logic             lock_q;
    logic [CH_W-1:0]  lock_idx_q;
    logic [CH_W-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [CH_W-1:0]  rr_pick;
    logic             rr_found;
    logic [CH_W-1:0]  grant;
    logic [CH_W-1:0]  rr_next;
    logic [CH_W-1:0]  head;
    logic             head_rdy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_val;
    logic             push;
    logic             pop;

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign req_val    = (|ch.ch_req_val_i) && !fifo_full;
    assign push       = req_val && mem.mem_req_rdy_i;
    assign grant      = lock_q ? lock_idx_q : rr_pick;
    assign rr_next    = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    assign head       = fifo_q[rd_ptr_q];

    // First valid channel at or after rr_q, wrapping.
    always_comb begin
        rr_pick  = rr_q;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            int j;
            j = int'(rr_q) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!rr_found && ch.ch_req_val_i[j]) begin
                rr_found = 1'b1;
                rr_pick  = CH_W'(j);
            end
        end
    end

    // Request mux from the granted channel, zeroed when idle.
    always_comb begin
        mem.mem_req_val_o      = req_val;
        mem.mem_req_is_write_o = 1'b0;
        mem.mem_req_is_cas_o   = 1'b0;
        mem.mem_req_addr_o     = '0;
        mem.mem_req_data_o     = '0;
        mem.mem_req_cas_exp_o  = '0;
        ch.ch_req_rdy_o        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_val && grant == CH_W'(i)) begin
                mem.mem_req_is_write_o = ch.ch_req_is_write_i[i];
                mem.mem_req_is_cas_o   = ch.ch_req_is_cas_i[i];
                mem.mem_req_addr_o     = ch.ch_req_addr_i[i];
                mem.mem_req_data_o     = ch.ch_req_data_i[i];
                mem.mem_req_cas_exp_o  = ch.ch_req_cas_exp_i[i];
                ch.ch_req_rdy_o[i]     = mem.mem_req_rdy_i;
            end
        end
    end

    // Response steering to the channel at the FIFO head.
    always_comb begin
        head_rdy        = 1'b0;
        ch.ch_rsp_val_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (head == CH_W'(i)) begin
                head_rdy        = ch.ch_rsp_rdy_i[i];
                ch.ch_rsp_val_o[i] = mem.mem_rsp_val_i && !fifo_empty;
            end
        end
    end

    assign mem.mem_rsp_rdy_o = fifo_empty ? 1'b1 : head_rdy;
    assign ch.ch_rsp_data_o  = mem.mem_rsp_data_i;
    assign pop               = mem.mem_rsp_val_i && head_rdy && !fifo_empty;
    assign outstanding_o     = cnt_q;
    assign err_unexp_rsp_o   = err_q;

    // Arbiter pointer, grant lock, FIFO pointers, occupancy and error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) begin
                rr_q     <= rr_next;
                lock_q   <= 1'b0;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end else if (req_val) begin
                lock_q     <= 1'b1;
                lock_idx_q <= grant;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (mem.mem_rsp_val_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // Tag storage; contents are only meaningful between pointers.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= grant;
    end

endmodule
